// File: rtl/vga_timing_pkg.sv
// Shared timing constants, RGB332 field positions and the window-compare helper
// for the 640x480@60 VGA display path.
package vga_timing_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int R_HI = 7;
  localparam int R_LO = 5;
  localparam int G_HI = 4;
  localparam int G_LO = 2;
  localparam int B_HI = 1;
  localparam int B_LO = 0;

  // True when cnt lies in [start, start+len-1]; a zero length never matches.
  function automatic logic in_window(input logic [9:0] cnt,
                                     input int unsigned start,
                                     input int unsigned len);
    int unsigned c;
    c = {22'd0, cnt};
    return (c >= start) && (c < start + len);
  endfunction

endpackage

// File: rtl/vga_timing_driver_pixel_delay_line.sv
// Pixel-tick gated shift register; used to hold the raw act/hs/vs flags back
// until the matching colour arrives from the pattern generator.
module pixel_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pe,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] stages [DEPTH];

      // Flushing to zero means "blank, no sync" for the flags carried here.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else if (pe) begin
          stages[0] <= d;
          for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
      end

      assign q = stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_driver.sv
// VGA timing generator and pin driver: issues x/y to the pattern generator,
// takes back RGB332 colour and drives sync-aligned colour to the DAC pins.
module vga_timing_driver
  import vga_timing_pkg::*;
#(
  parameter int          CLK_DIV     = 4,
  parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
  parameter int unsigned H_FP        = VGA_H_FP,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_BP        = VGA_H_BP,
  parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
  parameter int unsigned V_FP        = VGA_V_FP,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_BP        = VGA_V_BP,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int          PIX_LATENCY = 1
) (
  input  logic       CLK_IN,
  input  logic       RST_IN,
  input  logic [7:0] memRGB,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       FRAME_CLOCK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic [2:0] VGA_R,
  output logic [2:0] VGA_G,
  output logic [1:0] VGA_B,
  output logic       ACTIVE
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);

  logic       pe;
  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       act_raw;
  logic       hs_raw;
  logic       vs_raw;
  logic [2:0] dly_q;
  logic       dly_act;
  logic       dly_hs;
  logic       dly_vs;

  generate
    if (CLK_DIV <= 1) begin : g_no_div
      assign pe = 1'b1;
    end else begin : g_div
      localparam int              DIV_W    = $clog2(CLK_DIV);
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
      logic [DIV_W-1:0] div;

      always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
          div <= '0;
        end else if (div == DIV_LAST) begin
          div <= '0;
        end else begin
          div <= div + 1'b1;
        end
      end

      assign pe = (div == DIV_LAST);
    end
  endgenerate

  always_comb begin
    x_next = x + 10'd1;
    y_next = y;
    if (x == H_LAST) begin
      x_next = '0;
      y_next = (y == V_LAST) ? '0 : y + 10'd1;
    end
  end

  // FRAME_CLOCK is computed from the next y so it rises together with y = V_ACTIVE.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      x           <= '0;
      y           <= '0;
      FRAME_CLOCK <= 1'b0;
    end else if (pe) begin
      x           <= x_next;
      y           <= y_next;
      FRAME_CLOCK <= (y_next == 10'(V_ACTIVE));
    end
  end

  assign act_raw = in_window(x, 0, H_ACTIVE) && in_window(y, 0, V_ACTIVE);
  assign hs_raw  = in_window(x, H_ACTIVE + H_FP, H_SYNC);
  assign vs_raw  = in_window(y, V_ACTIVE + V_FP, V_SYNC);

  pixel_delay_line #(
    .WIDTH(3),
    .DEPTH(PIX_LATENCY)
  ) u_delay (
    .clk(CLK_IN),
    .rst(RST_IN),
    .pe (pe),
    .d  ({act_raw, hs_raw, vs_raw}),
    .q  (dly_q)
  );

  assign {dly_act, dly_hs, dly_vs} = dly_q;

  // Colour is forced black outside the visible area so porches stay at 0 V.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
      ACTIVE <= 1'b0;
      VGA_HS <= ~SYNC_POL;
      VGA_VS <= ~SYNC_POL;
    end else if (pe) begin
      ACTIVE <= dly_act;
      VGA_HS <= dly_hs ? SYNC_POL : ~SYNC_POL;
      VGA_VS <= dly_vs ? SYNC_POL : ~SYNC_POL;
      if (dly_act) begin
        VGA_R <= memRGB[R_HI:R_LO];
        VGA_G <= memRGB[G_HI:G_LO];
        VGA_B <= memRGB[B_HI:B_LO];
      end else begin
        VGA_R <= '0;
        VGA_G <= '0;
        VGA_B <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_driver.sv
// Directed bench: full-size timing for pixel/hsync checks, a shrunken raster
// for frame-level sync, FRAME_CLOCK, mid-frame reset and inverted polarity.
module tb_vga_timing_driver;

  logic clk = 1'b0;
  logic rst_main;
  logic rst_c;

  int check_count = 0;
  int error_count = 0;

  always #5 clk = ~clk;

  // dut_a: full 640x480 timing, one pixel per clock, colour = issued x
  logic [7:0] gen_reg;
  logic [9:0] x_a, y_a;
  logic       fc_a, hs_a, vs_a, act_a;
  logic [2:0] r_a, g_a;
  logic [1:0] b_a;

  // Models the upstream generator: colour for x arrives one pixel later.
  always @(posedge clk) gen_reg <= x_a[7:0];

  vga_timing_driver #(.CLK_DIV(1)) dut_a (
    .CLK_IN(clk), .RST_IN(rst_main), .memRGB(gen_reg), .x(x_a), .y(y_a),
    .FRAME_CLOCK(fc_a), .VGA_HS(hs_a), .VGA_VS(vs_a),
    .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a), .ACTIVE(act_a)
  );

  // dut_b: default divider of 4, constant red
  logic [9:0] x_b, y_b;
  logic       fc_b, hs_b, vs_b, act_b;
  logic [2:0] r_b, g_b;
  logic [1:0] b_b;

  vga_timing_driver dut_b (
    .CLK_IN(clk), .RST_IN(rst_main), .memRGB(8'hE0), .x(x_b), .y(y_b),
    .FRAME_CLOCK(fc_b), .VGA_HS(hs_b), .VGA_VS(vs_b),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .ACTIVE(act_b)
  );

  // dut_c / dut_d: 25x13 raster (325 ticks per frame), opposite sync polarities
  logic [9:0] x_c, y_c, x_d, y_d;
  logic       fc_c, hs_c, vs_c, act_c, fc_d, hs_d, vs_d, act_d;
  logic [2:0] r_c, g_c, r_d, g_d;
  logic [1:0] b_c, b_d;

  vga_timing_driver #(
    .CLK_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)
  ) dut_c (
    .CLK_IN(clk), .RST_IN(rst_c), .memRGB(8'hFF), .x(x_c), .y(y_c),
    .FRAME_CLOCK(fc_c), .VGA_HS(hs_c), .VGA_VS(vs_c),
    .VGA_R(r_c), .VGA_G(g_c), .VGA_B(b_c), .ACTIVE(act_c)
  );

  vga_timing_driver #(
    .CLK_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)
  ) dut_d (
    .CLK_IN(clk), .RST_IN(rst_main), .memRGB(8'hFF), .x(x_d), .y(y_d),
    .FRAME_CLOCK(fc_d), .VGA_HS(hs_d), .VGA_VS(vs_d),
    .VGA_R(r_d), .VGA_G(g_d), .VGA_B(b_d), .ACTIVE(act_d)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Hold both resets for three edges, release on a falling edge.
  task automatic applyReset();
    @(negedge clk);
    rst_main = 1'b1;
    rst_c    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst_main = 1'b0;
    rst_c    = 1'b0;
  endtask

  initial begin
    int hs_low_a, first_hs_x_a;
    int hs_low_c, vs_low_c, act_cnt_c, fc_rises, fc_high, first_fc_t, fc_x, fc_y;
    int first_vs_t_c, hs_high_d, vs_high_d, first_vs_t_d, first_hs_t_c;
    logic fc_prev;
    int waited;

    rst_main = 1'b1;
    rst_c    = 1'b1;
    applyReset();

    checkOutput("reset_x_a", x_a, 0);
    checkOutput("reset_y_a", y_a, 0);
    checkOutput("reset_hs_a", hs_a, 1);
    checkOutput("reset_vs_a", vs_a, 1);
    checkOutput("reset_active_a", act_a, 0);
    checkOutput("reset_rgb_a", {r_a, g_a, b_a}, 0);
    checkOutput("reset_fc_a", fc_a, 0);
    checkOutput("reset_hs_d", hs_d, 0);
    checkOutput("reset_vs_d", vs_d, 0);

    releaseReset();

    // Phase 1: first line of full-size timing, plus divider behaviour.
    hs_low_a = 0;
    first_hs_x_a = -1;
    for (int t = 1; t <= 800; t++) begin
      applyStimulus();
      if (!hs_a) begin
        if (hs_low_a == 0) first_hs_x_a = int'(x_a);
        hs_low_a++;
      end
      case (t)
        1: begin
          checkOutput("t1_x_a", x_a, 1);
          checkOutput("t1_active_a", act_a, 0);
        end
        2: begin
          checkOutput("t2_active_a", act_a, 1);
          checkOutput("t2_rgb_a", {r_a, g_a, b_a}, 0);
        end
        3:  checkOutput("t3_x_b", x_b, 0);
        4:  checkOutput("t4_x_b", x_b, 1);
        7: begin
          checkOutput("t7_r_a", r_a, 0);
          checkOutput("t7_g_a", g_a, 1);
          checkOutput("t7_b_a", b_a, 1);
          checkOutput("t7_x_b", x_b, 1);
          checkOutput("t7_active_b", act_b, 0);
        end
        8: begin
          checkOutput("t8_active_b", act_b, 1);
          checkOutput("t8_r_b", r_b, 7);
          checkOutput("t8_gb_b", {g_b, b_b}, 0);
        end
        11: checkOutput("t11_r_b", r_b, 7);
        12: checkOutput("t12_x_b", x_b, 3);
        200: checkOutput("t200_rgb_a", {r_a, g_a, b_a}, {3'd6, 3'd1, 2'd2});
        641: begin
          checkOutput("t641_active_a", act_a, 1);
          checkOutput("t641_rgb_a", {r_a, g_a, b_a}, {3'd3, 3'd7, 2'd3});
        end
        642: begin
          checkOutput("t642_active_a", act_a, 0);
          checkOutput("t642_rgb_a", {r_a, g_a, b_a}, 0);
        end
        800: begin
          checkOutput("t800_x_a", x_a, 0);
          checkOutput("t800_y_a", y_a, 1);
          checkOutput("t800_vs_a", vs_a, 1);
        end
        default: ;
      endcase
    end
    checkOutput("hs_low_ticks_a", hs_low_a, 96);
    checkOutput("hs_first_low_x_a", first_hs_x_a, 658);

    // Phase 2: two whole frames of the small raster.
    applyReset();
    releaseReset();
    hs_low_c = 0; vs_low_c = 0; act_cnt_c = 0;
    fc_rises = 0; fc_high = 0; first_fc_t = -1; fc_x = -1; fc_y = -1;
    first_vs_t_c = -1; hs_high_d = 0; vs_high_d = 0; first_vs_t_d = -1;
    fc_prev = 1'b0;
    for (int t = 1; t <= 650; t++) begin
      applyStimulus();
      if (!hs_c) hs_low_c++;
      if (!vs_c) begin
        if (vs_low_c == 0) first_vs_t_c = t;
        vs_low_c++;
      end
      if (act_c) act_cnt_c++;
      if (hs_d) hs_high_d++;
      if (vs_d) begin
        if (vs_high_d == 0) first_vs_t_d = t;
        vs_high_d++;
      end
      if (fc_c && !fc_prev) begin
        fc_rises++;
        if (fc_rises == 1) begin
          first_fc_t = t;
          fc_x = int'(x_c);
          fc_y = int'(y_c);
        end
      end
      if (fc_c) fc_high++;
      fc_prev = fc_c;
    end
    checkOutput("hs_low_ticks_c", hs_low_c, 104);
    checkOutput("vs_low_ticks_c", vs_low_c, 100);
    checkOutput("vs_first_low_t_c", first_vs_t_c, 227);
    checkOutput("active_ticks_c", act_cnt_c, 256);
    checkOutput("fc_rises_c", fc_rises, 2);
    checkOutput("fc_high_ticks_c", fc_high, 50);
    checkOutput("fc_first_rise_t_c", first_fc_t, 200);
    checkOutput("fc_rise_x_c", fc_x, 0);
    checkOutput("fc_rise_y_c", fc_y, 8);
    checkOutput("hs_high_ticks_d", hs_high_d, 104);
    checkOutput("vs_high_ticks_d", vs_high_d, 100);
    checkOutput("vs_first_high_t_d", first_vs_t_d, 227);

    // Phase 3: reset dut_c in the middle of a vertical and horizontal sync pulse.
    waited = 0;
    while (!(x_c == 10'd20 && y_c == 10'd9) && waited < 1000) begin
      applyStimulus();
      waited++;
    end
    checkOutput("wait_sync_pos_c", (waited < 1000) ? 1 : 0, 1);
    @(negedge clk);
    rst_c = 1'b1;
    applyStimulus();
    checkOutput("midrst_xy_c", {x_c, y_c}, 0);
    checkOutput("midrst_hs_c", hs_c, 1);
    checkOutput("midrst_vs_c", vs_c, 1);
    checkOutput("midrst_active_c", act_c, 0);
    checkOutput("midrst_rgb_c", {r_c, g_c, b_c}, 0);
    checkOutput("midrst_fc_c", fc_c, 0);
    @(negedge clk);
    rst_c = 1'b0;

    hs_low_c = 0; vs_low_c = 0; first_hs_t_c = -1; first_vs_t_c = -1;
    for (int t = 1; t <= 325; t++) begin
      applyStimulus();
      if (!hs_c) begin
        if (hs_low_c == 0) first_hs_t_c = t;
        hs_low_c++;
      end
      if (!vs_c) begin
        if (vs_low_c == 0) first_vs_t_c = t;
        vs_low_c++;
      end
    end
    checkOutput("post_rst_hs_low_c", hs_low_c, 52);
    checkOutput("post_rst_hs_first_t_c", first_hs_t_c, 20);
    checkOutput("post_rst_vs_low_c", vs_low_c, 50);
    checkOutput("post_rst_vs_first_t_c", first_vs_t_c, 227);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/vga_timing_driver.md
Name: vga_timing_driver

Overview:
- Display-side consumer of the pixel-colour interface: generates 640x480@60 VGA timing, issues pixel coordinates (x, y) and a once-per-frame FRAME_CLOCK to the image/pattern generator, and takes back its 8-bit RGB332 colour (memRGB).
- Registers memRGB, aligns it with delayed sync/blank, and drives the VGA connector pins.
- Sits at top level between the pattern generator and the board's resistor DAC.

Parameters:
- CLK_DIV, 4, CLK_IN cycles per pixel (100 MHz -> 25 MHz); 1 = every cycle
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch (H_TOTAL = 800)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch (V_TOTAL = 525)
- SYNC_POL, 0, asserted level of VGA_HS/VGA_VS (0 = active-low)
- PIX_LATENCY, 1, pixel ticks from x/y issue to valid memRGB (range 0..4)

Ports:
- CLK_IN  in  1  system clock
- RST_IN  in  1  synchronous active-high reset
- memRGB  in  8  pixel colour for current x/y: [7:5] R, [4:2] G, [1:0] B
- x  out  10  horizontal count 0..H_TOTAL-1, registered
- y  out  10  vertical count 0..V_TOTAL-1, registered
- FRAME_CLOCK  out  1  registered frame strobe, one rising edge per frame
- VGA_HS  out  1  horizontal sync
- VGA_VS  out  1  vertical sync
- VGA_R  out  3  red
- VGA_G  out  3  green
- VGA_B  out  2  blue
- ACTIVE  out  1  high while VGA_R/G/B carry a visible pixel

Behaviour:
- Clocking: single clock CLK_IN. Reset is synchronous, active-high (RST_IN), sampled only on the rising edge of CLK_IN.
- Pixel tick (pe): divider counts 0..CLK_DIV-1; pe is high when the divider is CLK_DIV-1. pe is constant 1 when CLK_DIV = 1. All state below advances only on pe.
- Counters: x increments each pe. At H_TOTAL-1, x wraps to 0 and y increments. At y = V_TOTAL-1 with x = H_TOTAL-1, both wrap to 0.
- x and y are raw counts: they keep running through blanking and are never clamped.
- Raw timing, combinational from x/y:
  - act = (x < H_ACTIVE) && (y < V_ACTIVE)
  - hs = x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
  - vs = y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]
- Alignment:
  - act/hs/vs pass through a pe-gated delay of PIX_LATENCY stages.
  - On each pe, memRGB and the delayed signals are captured into the output register.
  - The colour for the coordinate issued at pe tick N appears on the pins from pe tick N+PIX_LATENCY+1, together with its own sync/active.
- Outputs:
  - VGA_R/G/B = captured memRGB fields when delayed act = 1, else 0 (blanking forced black).
  - VGA_HS/VGA_VS = SYNC_POL when the delayed hs/vs is asserted, else ~SYNC_POL.
  - ACTIVE = delayed act.
- FRAME_CLOCK:
  - Registered; high for the entire line y = V_ACTIVE (first front-porch line), low otherwise.
  - Gives exactly one rising edge per frame, after the last visible pixel has been issued. It is glitch-free and safe to use as a clock.
- Reset values:
  - divider, x, y = 0; delay line flushed to blank/non-sync.
  - VGA_R/G/B = 0; ACTIVE = 0; FRAME_CLOCK = 0.
  - VGA_HS = VGA_VS = ~SYNC_POL.
- Reset mid-frame: all of the above is restored on the next edge. After release the first pe issues (0,0) and the frame restarts; no partial sync pulse is stretched.
- Width rules:
  - Counters are 10 bits, and H_TOTAL/V_TOTAL must be <= 1024.
  - Comparisons are unsigned.
  - memRGB is consumed as-is, with no dithering.

Decomposition:
- Package vga_timing_pkg holds:
  - 640x480@60 timing constants and derived H_TOTAL/V_TOTAL
  - RGB332 field slice constants (R 7:5, G 4:2, B 1:0)
  - the helper function for sync window compare
- One sub-module, pixel_delay_line: pe-gated shift register parameterised by width and depth. Depth 0 is a pass-through. It carries {act, hs, vs}.

Test Plan:
- CLK_DIV=1, PIX_LATENCY=1, memRGB = x[7:0]: after reset, x goes 0,1,2…, and the first visible pins at tick 2 give R=0,G=0,B=0. x=5 issued -> tick 7 shows R=0,G=1,B=1; x=639 -> visible, x=640 -> pins black, ACTIVE=0.
- Full frame, CLK_DIV=1: VGA_HS low for exactly 96 ticks starting at delayed x=656; VGA_VS low for exactly 2 lines (y=490,491) = 1600 ticks; period 800 x 525 = 420000 ticks.
- FRAME_CLOCK: exactly one rising edge per 420000 ticks, coincident with x=0,y=480; high for 800 ticks.
- CLK_DIV=4: x advances once per 4 CLK_IN cycles. memRGB=8'hE0 -> VGA_R=7, others 0, each pixel held 4 cycles.
- RST_IN asserted for 1 cycle at x=300,y=200: next edge x=y=0, pins black, syncs inactive. The first post-reset frame has full-width sync pulses.
- SYNC_POL=1: VGA_HS/VGA_VS idle low and pulse high with identical timing to the default case.
